// File: rtl/seq_frame_transmitter.sv
// Serialises DATA_W-bit words MSB first behind a fixed sync preamble, followed by an idle gap.
// Optional macro PARITY_EN appends one even-parity bit after the payload.
module seq_frame_transmitter #(
  parameter int               DATA_W   = 8,
  parameter int               PRE_W    = 4,
  parameter logic [PRE_W-1:0] PREAMBLE = PRE_W'(4'b1010),
  parameter int               GAP      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out,
  output logic              out_valid,
  output logic              busy
);

  localparam int MAX_A = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int MAX_C = (MAX_A > GAP) ? MAX_A : GAP;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
`ifdef PARITY_EN
    S_PAR,
`endif
    S_GAP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic [PRE_W-1:0]  pre_sr;
`ifdef PARITY_EN
  logic              parity;
`endif

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  // out/out_valid are loaded on the edge that enters each bit cycle, so the
  // first preamble bit appears in the cycle right after the accept edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      pre_sr    <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
`ifdef PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shreg     <= in_data;
            pre_sr    <= PREAMBLE << 1;
            out       <= PREAMBLE[PRE_W-1];
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= S_PRE;
`ifdef PARITY_EN
            parity    <= ^in_data;
`endif
          end
        end
        S_PRE: begin
          if (cnt == PRE_LAST) begin
            cnt   <= '0;
            out   <= shreg[DATA_W-1];
            shreg <= shreg << 1;
            state <= S_DATA;
          end else begin
            cnt    <= cnt + 1'b1;
            out    <= pre_sr[PRE_W-1];
            pre_sr <= pre_sr << 1;
          end
        end
        S_DATA: begin
          if (cnt == DATA_LAST) begin
            cnt <= '0;
`ifdef PARITY_EN
            out   <= parity;
            state <= S_PAR;
`else
            out       <= 1'b0;
            out_valid <= 1'b0;
            state     <= S_GAP;
`endif
          end else begin
            cnt   <= cnt + 1'b1;
            out   <= shreg[DATA_W-1];
            shreg <= shreg << 1;
          end
        end
`ifdef PARITY_EN
        S_PAR: begin
          cnt       <= '0;
          out       <= 1'b0;
          out_valid <= 1'b0;
          state     <= S_GAP;
        end
`endif
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
          cnt       <= '0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frame_transmitter.sv
// Cycle-accurate scoreboard bench for seq_frame_transmitter (default build and a small GAP=3/DATA_W=4 instance).
module tb_seq_frame_transmitter;

  localparam logic [3:0] PRE = 4'b1010;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready, out, out_valid, busy;

  logic [3:0] in_data2;
  logic       in_valid2;
  logic       in_ready2, out2, out_valid2, busy2;

  int n_checks = 0;
  int n_fail   = 0;

  // Each entry is the expected {out, out_valid, in_ready, busy} for one cycle.
  logic [3:0] sbq[$];

  seq_frame_transmitter dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .busy(busy)
  );

  seq_frame_transmitter #(.DATA_W(4), .PRE_W(4), .PREAMBLE(4'b1010), .GAP(3)) dut2 (
    .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .out(out2), .out_valid(out_valid2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push_frame(input logic [7:0] w);
    for (int i = 3; i >= 0; i--) sbq.push_back({PRE[i], 1'b1, 1'b0, 1'b1});
    for (int i = 7; i >= 0; i--) sbq.push_back({w[i], 1'b1, 1'b0, 1'b1});
`ifdef PARITY_EN
    sbq.push_back({^w, 1'b1, 1'b0, 1'b1});
`endif
    sbq.push_back(4'b0001);
    sbq.push_back(4'b0010);
  endfunction

  task automatic test_reset();
    logic [3:0] act;
    reset = 1'b1; in_valid = 1'b1; in_data = 8'hC5;
    #1;
    act = {out, out_valid, in_ready, busy};
    n_checks++;
    if (act !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL reset_async: got out/ov/rdy/busy=%b expected %b", act, 4'b0010);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      act = {out, out_valid, in_ready, busy};
      n_checks++;
      if (act !== 4'b0010) begin
        n_fail++;
        $display("[TB] FAIL reset_with_valid cyc %0d: got %b expected %b", i, act, 4'b0010);
      end
    end
    in_valid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      act = {out, out_valid, in_ready, busy};
      n_checks++;
      if (act !== 4'b0010) begin
        n_fail++;
        $display("[TB] FAIL idle cyc %0d: got %b expected %b", i, act, 4'b0010);
      end
    end
  endtask

  task automatic test_single_frame(input logic [7:0] w, input bit chk_det);
    logic [3:0] act, e;
    logic [3:0] det;
    int n, first_hit;
    det = 4'b0000;
    first_hit = 0;
    @(negedge clk);
    in_data = w; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    push_frame(w);
    n = sbq.size();
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      e = sbq.pop_front();
      act = {out, out_valid, in_ready, busy};
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("[TB] FAIL frame_%h k+%0d: got %b expected %b", w, i, act, e);
      end
      det = {det[2:0], out};
      if (first_hit == 0 && det == PRE) first_hit = i;
    end
    if (chk_det) begin
      n_checks++;
      if (first_hit != 4) begin
        n_fail++;
        $display("[TB] FAIL loopback_detect: got first match at k+%0d expected k+4", first_hit);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] act, e;
    int n;
    @(negedge clk);
    in_data = 8'hFF; in_valid = 1'b1;
    @(posedge clk);
    #1 in_data = 8'h00;
    push_frame(8'hFF);
    push_frame(8'h00);
    sbq.push_back(4'b0010);
    sbq.push_back(4'b0010);
    n = sbq.size();
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      e = sbq.pop_front();
      act = {out, out_valid, in_ready, busy};
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("[TB] FAIL back_to_back k+%0d: got %b expected %b", i, act, e);
      end
      if (i == 15) in_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] act, e;
    @(negedge clk);
    in_data = 8'hA5; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    push_frame(8'hA5);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      e = sbq.pop_front();
      act = {out, out_valid, in_ready, busy};
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("[TB] FAIL abort_frame k+%0d: got %b expected %b", i, act, e);
      end
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    act = {out, out_valid, in_ready, busy};
    n_checks++;
    if (act !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL abort_async: got %b expected %b", act, 4'b0010);
    end
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    act = {out, out_valid, in_ready, busy};
    n_checks++;
    if (act !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL after_abort: got %b expected %b", act, 4'b0010);
    end
    test_single_frame(8'h3C, 1'b0);
  endtask

  task automatic test_small_gap();
    logic [3:0] act, e;
    int n;
    @(negedge clk);
    in_data2 = 4'hA; in_valid2 = 1'b1;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    for (int i = 3; i >= 0; i--) sbq.push_back({PRE[i], 1'b1, 1'b0, 1'b1});
    for (int i = 3; i >= 0; i--) sbq.push_back({in_data2[i], 1'b1, 1'b0, 1'b1});
`ifdef PARITY_EN
    sbq.push_back({^in_data2, 1'b1, 1'b0, 1'b1});
`endif
    for (int i = 0; i < 3; i++) sbq.push_back(4'b0001);
    sbq.push_back(4'b0010);
    n = sbq.size();
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      e = sbq.pop_front();
      act = {out2, out_valid2, in_ready2, busy2};
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("[TB] FAIL small_gap k+%0d: got %b expected %b", i, act, e);
      end
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    test_single_frame(8'h07, 1'b0);
    test_single_frame(8'h03, 1'b0);
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    in_valid2 = 1'b0; in_data2 = 4'h0;
    test_reset();
    test_single_frame(8'hC5, 1'b1);
    test_back_to_back();
    test_reset_mid();
    test_small_gap();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
